dot_product_sched: RTL and testbench
====================================

DOT_PRODUCT_SCHED -- requirements
Module: dot_product_sched

Interface
REQ-001 SHALL have parameter CHUNK, default 8: bits of the vector pair processed per cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1: requester n presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b, input, 32 each: operand vectors of requester n.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1: requester n's pair is accepted on this edge when valid && ready.
REQ-007 SHALL have port out_valid, output, 1: result available.
REQ-008 SHALL have port out_id, output, 1: index of the requester that owns out_result.
REQ-009 SHALL have port out_result, output, 6: dot product = number of bit positions i with a[i]=b[i]=1, range 0..32.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result on this edge when out_valid && out_ready.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-012 In IDLE, SHALL grant exactly one valid requester; if both are valid, SHALL grant the one not granted last (round-robin); if one is valid, SHALL grant it.
REQ-013 SHALL drive reqN_ready high only in IDLE, and only for the granted requester, combinationally from the reqN_valid inputs and the round-robin pointer.
REQ-014 On accept, SHALL latch a, b and the requester id, clear the accumulator and chunk counter, update the round-robin pointer to the granted id, and go to CALC.
REQ-015 In CALC, SHALL add popcount(a[k*CHUNK +: CHUNK] & b[k*CHUNK +: CHUNK]) to the accumulator on each cycle k = 0..32/CHUNK-1, least significant chunk first.
REQ-016 SHALL go from CALC to DONE on the edge that adds the last chunk; out_valid SHALL rise exactly 32/CHUNK cycles after the accept edge (4 cycles at CHUNK=8).
REQ-017 Accumulator SHALL be 6 bits wide and SHALL NOT overflow; the all-ones pair SHALL give 32.
REQ-018 In DONE, SHALL hold out_valid=1 and keep out_result and out_id stable until out_ready; on out_valid && out_ready, SHALL return to IDLE.
REQ-019 SHALL keep both reqN_ready low in CALC and DONE; new valids SHALL wait and SHALL NOT disturb the operation in progress.
REQ-020 Minimum spacing between accepts SHALL be 32/CHUNK+2 cycles (one CALC run, one DONE cycle, one IDLE cycle).
REQ-021 A requester that drops valid before ready SHALL simply not be granted; there is no penalty and no state change.
REQ-022 out_valid, out_id and out_result SHALL be driven from registers; out_result SHALL read 0 whenever out_valid is 0.

Reset
REQ-023 reset SHALL dominate all other inputs on the same edge: FSM goes to IDLE, accumulator=0, counter=0, out_valid=0, out_id=0, out_result=0.
REQ-024 Reset SHALL set the round-robin pointer to "last granted = 1", so req0 wins the first contention.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation and discard its result; no out_valid pulse SHALL follow.

Structure
REQ-026 Shared package dp_pkg SHALL hold WORD_W=32, RESULT_W=6, the FSM state encoding and the requester-id width.
REQ-027 SHALL instantiate one combinational sub-module dp_chunk_popcount (CHUNK-bit AND then popcount, output width clog2(CHUNK)+1).
REQ-028 Counter width SHALL be clog2(32/CHUNK), minimum 1 bit; the counter SHALL stop at its terminal count (no wrap is ever observed).

Verification
REQ-029 req0 a=32'hFFFF_FFFF, b=32'hFFFF_FFFF, out_ready=1 -> out_valid 4 cycles after accept, out_result=32, out_id=0.
REQ-030 req1 a=32'hF0F0_F0F0, b=32'hFF00_FF00 -> out_result=8, out_id=1; a=32'h0, b=32'hFFFF_FFFF -> 0.
REQ-031 Both valid continuously after reset, out_ready=1 -> grants alternate 0,1,0,1 and accepts are spaced 6 cycles apart.
REQ-032 Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_result and out_id stay stable, both readies stay 0, and a single transfer occurs when out_ready rises.
REQ-033 Assert reset on the 2nd CALC cycle -> next cycle all outputs are 0, no stale out_valid, and the next contention grants req0.
REQ-034 Repeat REQ-029/REQ-030 at CHUNK=1 and CHUNK=32 -> latency 32 and 1 cycle respectively, same results.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared widths, FSM encoding and helpers for the chunked dot-product scheduler.
package dp_pkg;

   localparam int WORD_W   = 32;
   localparam int RESULT_W = 6;
   localparam int ID_W     = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Chunk counter needs at least one bit even when a single chunk covers the word.
   function automatic int cnt_width(input int chunk);
      int steps;
      steps = WORD_W / chunk;
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/dp_chunk_popcount.sv
// Combinational AND-then-popcount over one CHUNK-bit slice of the operand pair.
module dp_chunk_popcount #(
   parameter int CHUNK = 8,
   parameter int PC_W  = $clog2(CHUNK) + 1
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic [PC_W-1:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < CHUNK; i++) begin
         count = count + PC_W'(a[i] & b[i]);
      end
   end

endmodule

// File: rtl/dot_product_sched.sv
// Two-requester round-robin scheduler feeding a chunk-serial bitwise dot product.
//
// state   | meaning
// IDLE    | waiting for a requester; ready offered to the granted one
// CALC    | accumulating one chunk popcount per cycle, LS chunk first
// DONE    | result held on out_* until the consumer takes it
module dot_product_sched
   import dp_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0_valid,
   input  logic [WORD_W-1:0]   req0_a,
   input  logic [WORD_W-1:0]   req0_b,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [WORD_W-1:0]   req1_a,
   input  logic [WORD_W-1:0]   req1_b,
   output logic                req1_ready,
   output logic                out_valid,
   output logic                out_id,
   output logic [RESULT_W-1:0] out_result,
   input  logic                out_ready
);

   localparam int STEPS = WORD_W / CHUNK;
   localparam int CNT_W = cnt_width(CHUNK);
   localparam int PC_W  = $clog2(CHUNK) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

   state_t              state;
   logic [WORD_W-1:0]   a_q;
   logic [WORD_W-1:0]   b_q;
   logic [ID_W-1:0]     id_q;
   logic [ID_W-1:0]     rr_last;
   logic [ID_W-1:0]     grant_id;
   logic [RESULT_W-1:0] acc;
   logic [RESULT_W-1:0] acc_next;
   logic [CNT_W-1:0]    cnt;
   logic [PC_W-1:0]     chunk_pc;
   logic                accept;

   always_comb begin
      grant_id = ID_W'(0);
      if (req0_valid && req1_valid) begin
         grant_id = ~rr_last;
      end else if (req1_valid) begin
         grant_id = ID_W'(1);
      end
   end

   assign req0_ready = (state == ST_IDLE) && req0_valid && (grant_id == ID_W'(0));
   assign req1_ready = (state == ST_IDLE) && req1_valid && (grant_id == ID_W'(1));
   assign accept     = req0_ready || req1_ready;

   // Operands are shifted down each CALC cycle so the low slice is always the current chunk.
   dp_chunk_popcount #(
      .CHUNK (CHUNK),
      .PC_W  (PC_W)
   ) u_popcount (
      .a     (a_q[CHUNK-1:0]),
      .b     (b_q[CHUNK-1:0]),
      .count (chunk_pc)
   );

   assign acc_next = acc + RESULT_W'(chunk_pc);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= '0;
         rr_last    <= ID_W'(1);
         acc        <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_id     <= 1'b0;
         out_result <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q     <= grant_id[0] ? req1_a : req0_a;
                  b_q     <= grant_id[0] ? req1_b : req0_b;
                  id_q    <= grant_id;
                  rr_last <= grant_id;
                  acc     <= '0;
                  cnt     <= '0;
                  state   <= ST_CALC;
               end
            end
            ST_CALC: begin
               acc <= acc_next;
               a_q <= a_q >> CHUNK;
               b_q <= b_q >> CHUNK;
               if (cnt == CNT_LAST) begin
                  out_valid  <= 1'b1;
                  out_result <= acc_next;
                  out_id     <= id_q[0];
                  state      <= ST_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  out_result <= '0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product_sched.sv
// Bench for dot_product_sched at CHUNK = 8, 1 and 32 against a transaction-level model.
module tb_dot_product_sched;

   localparam int N = 3;

   function automatic int chunk_of(input int d);
      return (d == 0) ? 8 : ((d == 1) ? 1 : 32);
   endfunction

   logic                     clk = 1'b0;
   logic                     reset;
   logic [N-1:0][1:0]        rv;
   logic [N-1:0][1:0][31:0]  ra;
   logic [N-1:0][1:0][31:0]  rb;
   logic [N-1:0]             ordy;
   wire  [N-1:0][1:0]        rdy;
   wire  [N-1:0]             ov;
   wire  [N-1:0]             oid;
   wire  [N-1:0][5:0]        ores;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dot_product_sched #(.CHUNK(chunk_of(g))) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req0_valid (rv[g][0]),
         .req0_a     (ra[g][0]),
         .req0_b     (rb[g][0]),
         .req0_ready (rdy[g][0]),
         .req1_valid (rv[g][1]),
         .req1_a     (ra[g][1]),
         .req1_b     (rb[g][1]),
         .req1_ready (rdy[g][1]),
         .out_valid  (ov[g]),
         .out_id     (oid[g]),
         .out_result (ores[g]),
         .out_ready  (ordy[g])
      );
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Transaction-level model: 0 = free, 1 = computing, 2 = holding a result.
   int   m_phase [N];
   int   m_left  [N];
   int   m_res   [N];
   logic m_id    [N];
   logic m_last  [N];
   bit   m_on = 1'b0;

   always @(posedge clk) begin
      logic g;
      for (int d = 0; d < N; d++) begin
         if (reset) begin
            m_phase[d] = 0;
            m_last[d]  = 1'b1;
         end else begin
            case (m_phase[d])
               0: if (rv[d] != 2'b00) begin
                  g = (rv[d] == 2'b11) ? !m_last[d] : rv[d][1];
                  m_last[d]  = g;
                  m_id[d]    = g;
                  m_res[d]   = $countones(ra[d][g] & rb[d][g]);
                  m_left[d]  = 32 / chunk_of(d);
                  m_phase[d] = 1;
               end
               1: begin
                  m_left[d] = m_left[d] - 1;
                  if (m_left[d] == 0) m_phase[d] = 2;
               end
               2: if (ordy[d]) m_phase[d] = 0;
               default: m_phase[d] = 0;
            endcase
         end
      end
      if (reset) m_on = 1'b1;
   end

   always @(negedge clk) begin
      if (m_on) begin
         for (int d = 0; d < N; d++) begin
            bit v, idle, e0, e1;
            v    = (m_phase[d] == 2);
            idle = (m_phase[d] == 0);
            e0   = idle && rv[d][0] && (!rv[d][1] || m_last[d]);
            e1   = idle && rv[d][1] && (!rv[d][0] || !m_last[d]);
            check($sformatf("d%0d out_valid", d), ov[d], v);
            check($sformatf("d%0d out_result", d), ores[d], v ? m_res[d] : 0);
            if (v) check($sformatf("d%0d out_id", d), oid[d], m_id[d]);
            check($sformatf("d%0d req0_ready", d), rdy[d][0], e0);
            check($sformatf("d%0d req1_ready", d), rdy[d][1], e1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int d, input int id, input logic [31:0] a, input logic [31:0] b,
                      input int exp_res, input int exp_lat);
      bit got;
      int n;
      ra[d][id] = a;
      rb[d][id] = b;
      rv[d][id] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (rdy[d][id]) got = 1'b1;
      end
      tick();
      rv[d][id] = 1'b0;
      check($sformatf("d%0d accept id%0d", d, id), got, 1);
      n = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         tick();
         n++;
         if (ov[d]) got = 1'b1;
      end
      check($sformatf("d%0d latency", d), n, exp_lat);
      check($sformatf("d%0d literal result", d), ores[d], exp_res);
      check($sformatf("d%0d literal id", d), oid[d], id);
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int gid [4];
      int gcyc[4];
      int k;
      bit got;

      reset = 1'b1;
      rv    = '0;
      ra    = '0;
      rb    = '0;
      ordy  = '1;
      repeat (2) tick();
      reset = 1'b0;
      check("reset out_valid", ov, 0);
      check("reset out_result", ores, 0);
      check("reset out_id", oid, 0);

      for (int d = 0; d < N; d++) begin
         run(d, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32 / chunk_of(d));
         run(d, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 8, 32 / chunk_of(d));
         run(d, 1, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32 / chunk_of(d));
      end
      run(0, 0, 32'h8000_0001, 32'h8000_0003, 2, 4);

      // Continuous contention right after reset: strict alternation, 6-cycle spacing.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ra[0][0] = 32'h0000_00FF; rb[0][0] = 32'h0000_00FF;
      ra[0][1] = 32'h0000_0001; rb[0][1] = 32'h0000_0003;
      rv[0] = 2'b11;
      k = 0;
      for (int i = 0; i < 100 && k < 4; i++) begin
         @(negedge clk);
         if (rdy[0][0] || rdy[0][1]) begin
            gid[k]  = rdy[0][1];
            gcyc[k] = cyc;
            k++;
         end
      end
      tick();
      rv[0] = 2'b00;
      repeat (8) tick();
      check("alternation grant count", k, 4);
      check("grant 0", gid[0], 0);
      check("grant 1", gid[1], 1);
      check("grant 2", gid[2], 0);
      check("grant 3", gid[3], 1);
      for (int j = 1; j < 4 && j < k; j++) check($sformatf("spacing %0d", j), gcyc[j] - gcyc[j-1], 6);

      // Consumer stalls for 10 cycles while both requesters wait.
      ordy[0] = 1'b0;
      run(0, 1, 32'hFFFF_0000, 32'hFFFF_FFFF, 16, 4);
      rv[0] = 2'b11;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall out_valid", ov[0], 1);
         check("stall out_result", ores[0], 16);
         check("stall out_id", oid[0], 1);
         check("stall readies", rdy[0], 0);
      end
      rv[0] = 2'b00;
      ordy[0] = 1'b1;
      tick();
      check("after transfer out_valid", ov[0], 0);
      check("after transfer out_result", ores[0], 0);
      repeat (3) tick();

      // Abort a req0 operation on its second CALC cycle.
      ra[0][0] = 32'hFFFF_FFFF; rb[0][0] = 32'hFFFF_FFFF;
      rv[0][0] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (rdy[0][0]) got = 1'b1;
      end
      tick();
      rv[0][0] = 1'b0;
      check("abort accept", got, 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort out_valid", ov[0], 0);
      check("abort out_result", ores[0], 0);
      check("abort out_id", oid[0], 0);
      check("abort readies", rdy[0], 0);
      repeat (6) tick();
      rv[0] = 2'b11;
      @(negedge clk);
      check("post-reset grant req0", rdy[0][0], 1);
      check("post-reset deny req1", rdy[0][1], 0);
      tick();
      rv[0] = 2'b00;
      repeat (8) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
